nx_ingress_packer: RTL and testbench

Host-side ingress stage directly upstream of the mesh inbound stream.
- Accepts a narrow host byte stream and packs consecutive beats into STREAM_WIDTH-wide mesh messages.
- Buffers packed words in a small FIFO and presents them on a valid/ready interface that connects straight to the mesh inbound_data/valid/ready port.
- Decouples host pacing from mesh back-pressure and supports early termination of a partial word.

---
 rtl/nx_pkg.sv | 21 ++
 rtl/nx_fifo.sv | 78 +++++++
 rtl/nx_ingress_packer.sv | 123 ++++++++++++
 tb/tb_nx_ingress_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nx_pkg.sv
// Shared constants for the mesh ingress/egress path.
// Holds the default mesh word width, host beat width and header-field
// positions that the mesh nodes decode from the first (MSB) beat.
package nx_pkg;

   localparam int NX_STREAM_WIDTH = 32;
   localparam int NX_HOST_WIDTH   = 8;

   // Header fields live in the first host beat, i.e. the word MSBs.
   localparam int NX_HDR_DEST_MSB = 31;
   localparam int NX_HDR_DEST_LSB = 28;
   localparam int NX_HDR_TYPE_MSB = 27;
   localparam int NX_HDR_TYPE_LSB = 24;

   // Packer word-assembly state: EMPTY means no beat of the current word held.
   typedef enum logic {
      PK_EMPTY   = 1'b0,
      PK_FILLING = 1'b1
   } pack_state_t;

endpackage

// File: rtl/nx_fifo.sv
// Generic first-word-fall-through FIFO with valid/ready on both sides.
// Latency: a word pushed into an empty FIFO is visible at pop side the next cycle.
// Backpressure: push_ready is the registered !full flag (no path from pop_ready).
// Ports: clk_i/rst_i (sync, active-low); push_data/push_valid/push_ready;
//        pop_data/pop_valid/pop_ready; level = exact occupancy 0..DEPTH.
module nx_fifo
   import nx_pkg::*;
#(
   parameter int WIDTH = NX_STREAM_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       push_valid,
   output logic                       push_ready,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic [LW-1:0]    count_d;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign push = push_valid && !full;
   assign pop  = pop_ready && !empty;

   always_comb begin
      count_d = count;
      if (push && !pop) begin
         count_d = count + LW'(1);
      end else if (pop && !push) begin
         count_d = count - LW'(1);
      end
   end

   // Storage carries no reset; empty gates the output instead.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_d;
         full  <= (count_d == DEPTH_L);
         empty <= (count_d == '0);
      end
   end

   assign push_ready = !full;
   assign pop_valid  = !empty;
   assign pop_data   = empty ? '0 : mem[rd_ptr];
   assign level      = count;

endmodule

// File: rtl/nx_ingress_packer.sv
// Packs narrow host beats (first beat in MSBs) into mesh words and queues them.
// Latency: word is valid on inbound_* the cycle after its final beat, if FIFO was empty.
// Backpressure: host_ready_o = registered !fifo_full; mesh stalls hold head word stable.
// Ports: clk_i/rst_i (sync, active-low); host_data_i/host_valid_i/host_last_i/host_ready_o;
//        inbound_data_o/inbound_valid_o/inbound_ready_i; fifo_level_o, idle_o, words_sent_o.
module nx_ingress_packer
   import nx_pkg::*;
#(
   parameter int STREAM_WIDTH = NX_STREAM_WIDTH,
   parameter int HOST_WIDTH   = NX_HOST_WIDTH,
   parameter int FIFO_DEPTH   = 4,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [HOST_WIDTH-1:0]         host_data_i,
   input  logic                          host_valid_i,
   input  logic                          host_last_i,
   output logic                          host_ready_o,
   output logic [STREAM_WIDTH-1:0]       inbound_data_o,
   output logic                          inbound_valid_o,
   input  logic                          inbound_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          idle_o,
   output logic [COUNT_WIDTH-1:0]        words_sent_o
);

   localparam int BEATS = STREAM_WIDTH / HOST_WIDTH;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   if (STREAM_WIDTH % HOST_WIDTH != 0) begin : g_bad_width
      $error("nx_ingress_packer: STREAM_WIDTH must be a multiple of HOST_WIDTH");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("nx_ingress_packer: FIFO_DEPTH must be a power of two >= 2");
   end

   pack_state_t              state_q;
   pack_state_t              state_d;
   logic [CW-1:0]            cnt_q;
   logic [CW-1:0]            cnt_d;
   logic [STREAM_WIDTH-1:0]  part_q;
   logic [STREAM_WIDTH-1:0]  part_d;
   logic [STREAM_WIDTH-1:0]  word;
   logic                     accept;
   logic                     push;
   logic                     fifo_ready;
   logic [COUNT_WIDTH-1:0]   sent_q;

   assign host_ready_o = fifo_ready;
   assign accept       = host_valid_i && host_ready_o;

   // Current partial word with the incoming beat dropped into its slot.
   always_comb begin
      word = part_q;
      for (int k = 0; k < BEATS; k++) begin
         if (cnt_q == CW'(k)) begin
            word[STREAM_WIDTH-1-k*HOST_WIDTH -: HOST_WIDTH] = host_data_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      part_d  = part_q;
      push    = 1'b0;
      if (accept) begin
         if ((cnt_q == LAST_BEAT) || host_last_i) begin
            // Unfilled beats stay zero because part_q only ever holds filled slots.
            push    = 1'b1;
            cnt_d   = '0;
            part_d  = '0;
            state_d = PK_EMPTY;
         end else begin
            cnt_d   = cnt_q + CW'(1);
            part_d  = word;
            state_d = PK_FILLING;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= PK_EMPTY;
         cnt_q   <= '0;
         part_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
      end
   end

   // push only fires when host_ready_o (= FIFO not full), so it is never dropped.
   nx_fifo #(
      .WIDTH (STREAM_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_data  (word),
      .push_valid (push),
      .push_ready (fifo_ready),
      .pop_data   (inbound_data_o),
      .pop_valid  (inbound_valid_o),
      .pop_ready  (inbound_ready_i),
      .level      (fifo_level_o)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sent_q <= '0;
      end else if (inbound_valid_o && inbound_ready_i && (sent_q != '1)) begin
         sent_q <= sent_q + COUNT_WIDTH'(1);
      end
   end

   assign words_sent_o = sent_q;
   assign idle_o       = !inbound_valid_o && (state_q == PK_EMPTY);

endmodule

// File: tb/tb_nx_ingress_packer.sv
module tb_nx_ingress_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  host_data = '0;
   logic        host_valid = 1'b0;
   logic        host_last = 1'b0;
   logic        host_ready;
   logic [31:0] inbound_data;
   logic        inbound_valid;
   logic        inbound_ready = 1'b1;
   logic [2:0]  fifo_level;
   logic        idle;
   logic [3:0]  words_sent;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] bp_words [4];

   always #5 clk = ~clk;

   nx_ingress_packer #(
      .STREAM_WIDTH (32),
      .HOST_WIDTH   (8),
      .FIFO_DEPTH   (4),
      .COUNT_WIDTH  (4)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .host_data_i     (host_data),
      .host_valid_i    (host_valid),
      .host_last_i     (host_last),
      .host_ready_o    (host_ready),
      .inbound_data_o  (inbound_data),
      .inbound_valid_o (inbound_valid),
      .inbound_ready_i (inbound_ready),
      .fifo_level_o    (fifo_level),
      .idle_o          (idle),
      .words_sent_o    (words_sent)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send_beat(input logic [7:0] d, input logic l);
      int guard;
      guard = 0;
      host_valid = 1'b1;
      host_data  = d;
      host_last  = l;
      while (!host_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("beat_ready_wait", 32'(host_ready), 32'd1);
      tick();
      host_valid = 1'b0;
      host_last  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) send_beat(w[31-8*b -: 8], 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bp_words[0] = 32'h10111213;
      bp_words[1] = 32'h14151617;
      bp_words[2] = 32'h18191A1B;
      bp_words[3] = 32'h1C1D1E1F;

      // Reset values
      #1;
      tick();
      tick();
      check("rst_host_ready", 32'(host_ready), 32'd1);
      check("rst_valid", 32'(inbound_valid), 32'd0);
      check("rst_data", inbound_data, 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_words", 32'(words_sent), 32'd0);
      rst = 1'b1;

      // Full word, mesh always ready
      send_beat(8'h12, 1'b0);
      send_beat(8'h34, 1'b0);
      send_beat(8'h56, 1'b0);
      check("full_valid_early", 32'(inbound_valid), 32'd0);
      check("full_idle_filling", 32'(idle), 32'd0);
      send_beat(8'h78, 1'b0);
      check("full_valid", 32'(inbound_valid), 32'd1);
      check("full_data", inbound_data, 32'h12345678);
      check("full_idle_queued", 32'(idle), 32'd0);
      tick();
      check("full_words", 32'(words_sent), 32'd1);
      check("full_idle_after", 32'(idle), 32'd1);
      check("full_valid_after", 32'(inbound_valid), 32'd0);

      // Partial word closed by host_last, next word restarts at MSBs
      send_beat(8'hAA, 1'b0);
      send_beat(8'hBB, 1'b1);
      check("part_valid", 32'(inbound_valid), 32'd1);
      check("part_data", inbound_data, 32'hAABB0000);
      tick();
      send_beat(8'hCC, 1'b1);
      check("part_next_data", inbound_data, 32'hCC000000);
      tick();
      check("part_words", 32'(words_sent), 32'd3);

      // Back-pressure: 16 beats fill the FIFO, 17th is refused
      inbound_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_beat(8'(8'h10 + i), 1'b0);
      check("bp_host_ready_low", 32'(host_ready), 32'd0);
      check("bp_level_full", 32'(fifo_level), 32'd4);
      host_valid = 1'b1;
      host_data  = 8'h20;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_data", inbound_data, bp_words[0]);
         check("bp_hold_level", 32'(fifo_level), 32'd4);
      end
      host_valid = 1'b0;
      inbound_ready = 1'b1;
      tick();
      check("bp_host_ready_rise", 32'(host_ready), 32'd1);
      for (int i = 1; i < 4; i++) begin
         check("bp_drain_data", inbound_data, bp_words[i]);
         check("bp_drain_level", 32'(fifo_level), 32'(4 - i));
         tick();
      end
      check("bp_drained_valid", 32'(inbound_valid), 32'd0);
      check("bp_words", 32'(words_sent), 32'd7);
      send_word(32'h20212223);
      check("bp_tail_data", inbound_data, 32'h20212223);
      tick();

      // Simultaneous push and pop at level 2
      inbound_ready = 1'b0;
      send_word(32'hA0A1A2A3);
      send_word(32'hB0B1B2B3);
      check("pp_level_pre", 32'(fifo_level), 32'd2);
      send_beat(8'hC0, 1'b0);
      send_beat(8'hC1, 1'b0);
      send_beat(8'hC2, 1'b0);
      inbound_ready = 1'b1;
      send_beat(8'hC3, 1'b0);
      inbound_ready = 1'b0;
      check("pp_level", 32'(fifo_level), 32'd2);
      check("pp_head", inbound_data, 32'hB0B1B2B3);
      inbound_ready = 1'b1;
      tick();
      check("pp_second", inbound_data, 32'hC0C1C2C3);
      tick();
      check("pp_empty", 32'(fifo_level), 32'd0);
      check("pp_words", 32'(words_sent), 32'd11);

      // Reset with 3 words queued and 2 beats held
      inbound_ready = 1'b0;
      send_word(32'h01020304);
      send_word(32'h05060708);
      send_word(32'h090A0B0C);
      send_beat(8'hEE, 1'b0);
      send_beat(8'hEF, 1'b0);
      check("mr_level_pre", 32'(fifo_level), 32'd3);
      check("mr_idle_pre", 32'(idle), 32'd0);
      rst = 1'b0;
      tick();
      check("mr_host_ready", 32'(host_ready), 32'd1);
      check("mr_valid", 32'(inbound_valid), 32'd0);
      check("mr_data", inbound_data, 32'd0);
      check("mr_level", 32'(fifo_level), 32'd0);
      check("mr_idle", 32'(idle), 32'd1);
      check("mr_words", 32'(words_sent), 32'd0);
      rst = 1'b1;
      inbound_ready = 1'b1;
      tick();
      tick();
      check("mr_no_emit", 32'(inbound_valid), 32'd0);
      send_word(32'h5A5B5C5D);
      check("mr_clean_word", inbound_data, 32'h5A5B5C5D);
      tick();
      check("mr_words_after", 32'(words_sent), 32'd1);

      // Saturation of the 4-bit sent counter
      for (int w = 0; w < 13; w++) send_word(32'(w) * 32'h01010101);
      tick();
      check("sat_below", 32'(words_sent), 32'd14);
      for (int w = 0; w < 6; w++) send_word(32'hF0F0F0F0);
      tick();
      check("sat_stop", 32'(words_sent), 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
